// File: rtl/alu_decoder_pipe.sv
// Registered, handshaked ALU control decoder for the MIPS32 EX stage.
// Maps alu_op/funct to an extended control code and sequences multi-cycle MULT/DIV issue.
module alu_decoder_pipe #(
    parameter int unsigned CTRL_W      = 4,
    parameter int unsigned MD_CYCLES   = 32,
    parameter bit          LEGACY_MODE = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        alu_op,
    input  logic [5:0]        funct,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              illegal,
    output logic              md_start,
    output logic              md_busy
);

    localparam int unsigned CNT_W = $clog2(MD_CYCLES + 1);

    typedef enum logic [3:0] {
        CTRL_AND  = 4'h0, CTRL_OR    = 4'h1, CTRL_ADD  = 4'h2, CTRL_XOR  = 4'h3,
        CTRL_NOR  = 4'h4, CTRL_SLL   = 4'h5, CTRL_SUB  = 4'h6, CTRL_SLT  = 4'h7,
        CTRL_SRL  = 4'h8, CTRL_SRA   = 4'h9, CTRL_SLTU = 4'hA, CTRL_LUI  = 4'hB,
        CTRL_MULT = 4'hC, CTRL_MULTU = 4'hD, CTRL_DIV  = 4'hE, CTRL_DIVU = 4'hF
    } alu_code_e;

    typedef enum logic {IDLE, MD_BUSY} state_e;

    state_e           state;
    logic [CNT_W-1:0] md_cnt;
    alu_code_e        dec_code;
    logic             dec_illegal;
    logic             dec_md;
    logic             legacy_funct_ok;
    logic             accept;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    assign legacy_funct_ok = funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    always_comb begin
        dec_code    = CTRL_ADD;
        dec_illegal = 1'b0;
        case (alu_op)
            3'b000: dec_code = CTRL_ADD;
            3'b001: dec_code = CTRL_SUB;
            3'b010: begin
                case (funct)
                    6'b100000, 6'b100001: dec_code = CTRL_ADD;
                    6'b100010, 6'b100011: dec_code = CTRL_SUB;
                    6'b100100: dec_code = CTRL_AND;
                    6'b100101: dec_code = CTRL_OR;
                    6'b100110: dec_code = CTRL_XOR;
                    6'b100111: dec_code = CTRL_NOR;
                    6'b101010: dec_code = CTRL_SLT;
                    6'b101011: dec_code = CTRL_SLTU;
                    6'b000000: dec_code = CTRL_SLL;
                    6'b000010: dec_code = CTRL_SRL;
                    6'b000011: dec_code = CTRL_SRA;
                    6'b011000: dec_code = CTRL_MULT;
                    6'b011001: dec_code = CTRL_MULTU;
                    6'b011010: dec_code = CTRL_DIV;
                    6'b011011: dec_code = CTRL_DIVU;
                    default:   dec_illegal = 1'b1;
                endcase
            end
            3'b011: dec_code = CTRL_AND;
            3'b100: dec_code = CTRL_OR;
            3'b101: dec_code = CTRL_XOR;
            3'b110: dec_code = CTRL_SLT;
            default: dec_code = CTRL_LUI;
        endcase
        // Legacy subset is applied as a filter over the full decode
        if (LEGACY_MODE) begin
            if (alu_op > 3'b010 || (alu_op == 3'b010 && !legacy_funct_ok)) begin
                dec_illegal = 1'b1;
            end
        end
        if (dec_illegal) begin
            dec_code = CTRL_ADD;
        end
    end

    assign dec_md = !dec_illegal && (alu_op == 3'b010) && (funct[5:2] == 4'b0110);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            md_cnt    <= '0;
            out_valid <= 1'b0;
            alu_ctrl  <= CTRL_W'(CTRL_ADD);
            illegal   <= 1'b0;
            md_start  <= 1'b0;
            md_busy   <= 1'b0;
        end else begin
            md_start <= 1'b0;

            if (accept) begin
                out_valid <= 1'b1;
                alu_ctrl  <= CTRL_W'(dec_code);
                illegal   <= dec_illegal;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept && dec_md) begin
                        state    <= MD_BUSY;
                        md_busy  <= 1'b1;
                        md_start <= 1'b1;
                        md_cnt   <= CNT_W'(MD_CYCLES);
                    end
                end
                MD_BUSY: begin
                    // Leaving on count 1 keeps md_busy high for exactly MD_CYCLES cycles
                    if (md_cnt <= CNT_W'(1)) begin
                        state   <= IDLE;
                        md_busy <= 1'b0;
                        md_cnt  <= '0;
                    end else begin
                        md_cnt <= md_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    md_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_decoder_pipe.sv
// Scoreboard bench for alu_decoder_pipe: a full-mode instance (MD_CYCLES=4)
// and a legacy-mode instance with a widened alu_ctrl.
module tb_alu_decoder_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] alu_op;
    logic [5:0] funct;
    logic       out_ready;

    logic       in_valid, in_ready, out_valid, illegal, md_start, md_busy;
    logic [3:0] alu_ctrl;

    logic       lg_in_valid, lg_in_ready, lg_out_valid, lg_illegal, lg_md_start, lg_md_busy;
    logic [5:0] lg_alu_ctrl;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [4:0] q0[$];
    logic [4:0] q1[$];

    always #5 clk = ~clk;

    alu_decoder_pipe #(.CTRL_W(4), .MD_CYCLES(4), .LEGACY_MODE(1'b0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct), .out_valid(out_valid), .out_ready(out_ready),
        .alu_ctrl(alu_ctrl), .illegal(illegal), .md_start(md_start), .md_busy(md_busy)
    );

    alu_decoder_pipe #(.CTRL_W(6), .MD_CYCLES(3), .LEGACY_MODE(1'b1)) dut_legacy (
        .clk(clk), .reset(reset), .in_valid(lg_in_valid), .in_ready(lg_in_ready),
        .alu_op(alu_op), .funct(funct), .out_valid(lg_out_valid), .out_ready(out_ready),
        .alu_ctrl(lg_alu_ctrl), .illegal(lg_illegal), .md_start(lg_md_start), .md_busy(lg_md_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference table: returns {illegal, code}
    function automatic logic [4:0] model(input logic [2:0] op, input logic [5:0] fn, input bit legacy);
        logic [3:0] c;
        logic       ill;
        c   = 4'h2;
        ill = 1'b0;
        case (op)
            3'd0: c = 4'h2;
            3'd1: c = 4'h6;
            3'd2: begin
                case (fn)
                    6'h20, 6'h21: c = 4'h2;
                    6'h22, 6'h23: c = 4'h6;
                    6'h24: c = 4'h0;
                    6'h25: c = 4'h1;
                    6'h26: c = 4'h3;
                    6'h27: c = 4'h4;
                    6'h2A: c = 4'h7;
                    6'h2B: c = 4'hA;
                    6'h00: c = 4'h5;
                    6'h02: c = 4'h8;
                    6'h03: c = 4'h9;
                    6'h18: c = 4'hC;
                    6'h19: c = 4'hD;
                    6'h1A: c = 4'hE;
                    6'h1B: c = 4'hF;
                    default: ill = 1'b1;
                endcase
            end
            3'd3: c = 4'h0;
            3'd4: c = 4'h1;
            3'd5: c = 4'h3;
            3'd6: c = 4'h7;
            default: c = 4'hB;
        endcase
        if (legacy) begin
            if (op >= 3'd3) ill = 1'b1;
            else if (op == 3'd2 && !(fn == 6'h20 || fn == 6'h22 || fn == 6'h24 ||
                                     fn == 6'h25 || fn == 6'h2A)) ill = 1'b1;
        end
        if (ill) c = 4'h2;
        return {ill, c};
    endfunction

    task automatic send(input bit sel, input logic [2:0] op, input logic [5:0] fn);
        int  n = 0;
        bit  ok = 1'b1;
        @(negedge clk);
        alu_op = op;
        funct  = fn;
        if (sel) lg_in_valid = 1'b1;
        else     in_valid    = 1'b1;
        #4;
        while (!(sel ? lg_in_ready : in_ready)) begin
            n++;
            if (n > 64) begin
                check("send_timeout", 32'(n), 32'(0));
                ok = 1'b0;
                break;
            end
            @(negedge clk);
            #4;
        end
        if (ok) begin
            if (sel) q1.push_back(model(op, fn, 1'b1));
            else     q0.push_back(model(op, fn, 1'b0));
            @(posedge clk);
        end
        #1;
        in_valid    = 1'b0;
        lg_in_valid = 1'b0;
    endtask

    // Monitors: compare on every consumed output, just before the clock edge
    initial forever begin
        logic [4:0] e;
        @(negedge clk);
        #4;
        if (!reset && out_valid && out_ready) begin
            check("sb0_underflow", 32'(q0.size() > 0), 32'(1));
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("alu_ctrl", 32'(alu_ctrl), 32'(e[3:0]));
                check("illegal", 32'(illegal), 32'(e[4]));
            end
        end
    end

    initial forever begin
        logic [4:0] e;
        @(negedge clk);
        #4;
        if (!reset && lg_out_valid && out_ready) begin
            check("sb1_underflow", 32'(q1.size() > 0), 32'(1));
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("lg_alu_ctrl", 32'(lg_alu_ctrl), 32'({2'b00, e[3:0]}));
                check("lg_illegal", 32'(lg_illegal), 32'(e[4]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [5:0] stream_fn[4];
        stream_fn = '{6'h20, 6'h22, 6'h26, 6'h2B};

        reset = 1'b1; in_valid = 1'b0; lg_in_valid = 1'b0;
        alu_op = 3'd0; funct = 6'd0; out_ready = 1'b1;
        #3;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_alu_ctrl", 32'(alu_ctrl), 32'(4'h2));
        check("rst_lg_alu_ctrl", 32'(lg_alu_ctrl), 32'(6'h02));
        check("rst_illegal", 32'(illegal), 32'(0));
        check("rst_md_start", 32'(md_start), 32'(0));
        check("rst_md_busy", 32'(md_busy), 32'(0));
        @(negedge clk);
        reset = 1'b0;

        // Basic add/sub with 1-cycle latency
        send(1'b0, 3'b000, 6'h3F);
        check("lat_valid", 32'(out_valid), 32'(1));
        check("lat_ctrl_add", 32'(alu_ctrl), 32'(4'h2));
        send(1'b0, 3'b001, 6'h00);
        check("lat_ctrl_sub", 32'(alu_ctrl), 32'(4'h6));

        // Full sweep of R-type functs plus remaining fixed alu_ops
        for (int f = 0; f < 64; f++) send(1'b0, 3'b010, 6'(f));
        for (int op = 3; op < 8; op++) send(1'b0, 3'(op), 6'h18);

        // Legacy instance: funct sweep and alu_op subset
        for (int f = 0; f < 64; f++) send(1'b1, 3'b010, 6'(f));
        for (int op = 0; op < 8; op++) if (op != 2) send(1'b1, 3'(op), 6'h20);
        repeat (6) @(negedge clk);

        // Back-to-back stream with out_ready held high
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; alu_op = 3'b010; funct = stream_fn[i];
            #4;
            check("stream_in_ready", 32'(in_ready), 32'(1));
            q0.push_back(model(3'b010, stream_fn[i], 1'b0));
            @(posedge clk);
            #1;
            check("stream_out_valid", 32'(out_valid), 32'(1));
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Backpressure: output held, no accept, release accepts same cycle
        out_ready = 1'b0;
        send(1'b0, 3'b010, 6'h25);
        @(negedge clk);
        in_valid = 1'b1; alu_op = 3'b010; funct = 6'h27;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #4;
            check("stall_in_ready", 32'(in_ready), 32'(0));
            check("stall_out_valid", 32'(out_valid), 32'(1));
            check("stall_alu_ctrl", 32'(alu_ctrl), 32'(4'h1));
        end
        @(negedge clk);
        out_ready = 1'b1;
        #4;
        check("release_in_ready", 32'(in_ready), 32'(1));
        q0.push_back(model(3'b010, 6'h27, 1'b0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("release_ctrl_nor", 32'(alu_ctrl), 32'(4'h4));
        repeat (3) @(negedge clk);

        // DIV: md_start one cycle, md_busy exactly 4 cycles
        send(1'b0, 3'b010, 6'h1A);
        check("div_ctrl", 32'(alu_ctrl), 32'(4'hE));
        check("div_md_start", 32'(md_start), 32'(1));
        check("div_md_busy_1", 32'(md_busy), 32'(1));
        for (int k = 1; k < 4; k++) begin
            @(posedge clk);
            #1;
            check("div_md_busy", 32'(md_busy), 32'(1));
            check("div_md_start_low", 32'(md_start), 32'(0));
            check("div_in_ready_low", 32'(in_ready), 32'(0));
        end
        @(posedge clk);
        #1;
        check("div_md_busy_end", 32'(md_busy), 32'(0));
        check("div_in_ready_end", 32'(in_ready), 32'(1));
        send(1'b0, 3'b011, 6'h00);
        repeat (2) @(negedge clk);

        // Illegal MD-range funct on legacy instance must not start busy
        send(1'b1, 3'b010, 6'h18);
        check("lg_no_md_start", 32'(lg_md_start), 32'(0));
        check("lg_no_md_busy", 32'(lg_md_busy), 32'(0));
        repeat (2) @(negedge clk);

        // Reset during the second md_busy cycle drops pending output
        out_ready = 1'b0;
        send(1'b0, 3'b010, 6'h1B);
        @(posedge clk);
        #1;
        check("pre_rst_md_busy", 32'(md_busy), 32'(1));
        #1;
        reset = 1'b1;
        #1;
        q0.delete();
        check("midrst_md_busy", 32'(md_busy), 32'(0));
        check("midrst_out_valid", 32'(out_valid), 32'(0));
        check("midrst_alu_ctrl", 32'(alu_ctrl), 32'(4'h2));
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'(1));
        send(1'b0, 3'b111, 6'h00);
        repeat (4) @(negedge clk);

        check("sb0_drained", 32'(q0.size()), 32'(0));
        check("sb1_drained", 32'(q1.size()), 32'(0));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
